rf_access_arbiter: RTL
======================

# rf_access_arbiter

Shares the CPU register file's single write port and a dedicated auxiliary read port between the core writeback stage and a debug host. It also provides an optional register-dump sequencer that streams every register out in address order. It sits beside the register file inside `cpu`, between writeback and `rf`. All debug, bench and end-of-run register inspection goes through it instead of hierarchical peeks.

## Interface
- `NUM_REGS`, 32, number of architectural registers
- `ADDR_W`, 5, register address width, must satisfy 2**ADDR_W >= NUM_REGS
- `DATA_W`, 64, register width
- `STARVE_LIMIT`, 4, consecutive cycles a debug write may lose to the core before the core is stalled (range 1..15)
- `clk  in  1  clock`; one clock; reset is synchronous and active-high
- `rst  in  1  synchronous active-high reset`
- `wb_en / wb_addr / wb_data  in  1/ADDR_W/DATA_W  core writeback request`
- `core_stall  out  1  core must freeze and hold its writeback this cycle`
- `dbg_req_valid, dbg_req_write  in  1  debug request valid; 1=write, 0=read`
- `dbg_req_addr / dbg_req_wdata  in  ADDR_W/DATA_W  debug address, write data`
- `dbg_req_ready  out  1  request accepted when valid && ready`
- `dbg_rsp_valid / dbg_rsp_rdata  out  1/DATA_W  one-cycle response pulse, no backpressure; rdata is 0 for writes`
- `dump_start  in  1  start-dump pulse`
- `dump_valid / dump_addr / dump_data / dump_done  out  1/ADDR_W/DATA_W/1  dump stream`
- `rf_we / rf_waddr / rf_wdata  out  1/ADDR_W/DATA_W  register-file write port`
- `rf_raddr  out  ADDR_W`; `rf_rdata  in  DATA_W`: auxiliary combinational read port

## Operation
- **Write port:** `rf_we/waddr/wdata` pass `wb_*` through combinationally, except in the one cycle where a debug write is granted.
- **FSM states:** IDLE, DBG_WR, DBG_RD, DUMP.
- **IDLE:** `dbg_req_ready` = !dump_start (dump_start wins a simultaneous arrival).
  - An accepted request latches addr/wdata and moves to DBG_WR or DBG_RD.
  - dump_start (macro on) moves to DUMP with the address counter at 0.
  - dump_start outside IDLE is ignored.
- **DBG_WR:**
  - If wb_en and starve_cnt < STARVE_LIMIT: the core wins, starve_cnt++, stay in DBG_WR.
  - Otherwise the debug write drives the port. core_stall is high only when wb_en && starve_cnt == STARVE_LIMIT.
  - On the grant: starve_cnt := 0, dbg_rsp_valid pulses next cycle, then return to IDLE.
- **DBG_RD (one cycle):** rf_raddr = latched addr.
  - Captured data = (wb_en && wb_addr == addr) ? wb_data : rf_rdata, so same-cycle writeback is forwarded.
  - dbg_rsp_valid pulses next cycle; return to IDLE.
- **DUMP:**
  - One register per cycle, addr 0..NUM_REGS-1, with the same forwarding rule.
  - Registered outputs: dump_valid, dump_addr, dump_data.
  - dump_done pulses together with the last beat (addr NUM_REGS-1).
  - Core writes proceed unstalled; dbg_req_ready = 0.
- The arbiter never special-cases any register address; the core owns zero-register semantics.
- The address counter stops at NUM_REGS-1 and does not wrap.

## Timing
- **Reset:** state IDLE, starve_cnt 0, dump counter 0.
  - All registered outputs are 0: dbg_rsp_valid, dbg_rsp_rdata, dump_valid, dump_addr, dump_data, dump_done.
  - core_stall is 0 and dbg_req_ready is 0 during reset.
  - Reset mid-operation drops the pending request or dump with no response or done pulse.
- **Read latency:** accept at T; sample at T+1; dbg_rsp_valid at T+2.
- **Write latency:** accept at T; earliest grant at T+1; response one cycle after the grant.
  - Worst-case grant is T+1+STARVE_LIMIT.
- **Back-to-back:** next request is accepted at the earliest in the response cycle (ready is high again in IDLE).
- **Dump:** start at T; beats at T+2..T+1+NUM_REGS; the dump takes NUM_REGS+1 cycles to return to IDLE.
- **core_stall** is combinational from state and starve_cnt, and asserts for at most one cycle per debug write.

## Configuration
- `RF_ARB_DUMP_EN` defined: the DUMP state and sequencer are compiled in.
- Undefined: dump ports remain, tied to 0; dump_start is ignored; dbg_req_ready depends on state only.

## Structure
- **Package `rf_arb_pkg`:** state enum `rf_arb_state_e` and the starve-counter width constant `STARVE_CNT_W = 4`.
- **Sub-module `rf_dump_seq`:** address counter plus dump_valid/dump_done generation. Instantiated only under RF_ARB_DUMP_EN.

## Test plan
- **Debug read with no core traffic:** write r5 = 0x1234 via debug, then read r5 → dbg_rsp_rdata = 0x1234, response 2 cycles after accept.
- **Forwarding:** debug read r7 while the core writes r7 = 0xAA in the sample cycle → response 0xAA.
- **Starvation:** wb_en held high continuously; debug write to r3 with STARVE_LIMIT=4.
  - Core wins 4 cycles; core_stall=1 on cycle 5 and the debug write lands.
  - The core write held over the stall lands next cycle; r3 holds debug data unless the core also targets r3.
- **Dump:** preload r0..r31 = index*3, then pulse dump_start.
  - 32 beats with dump_data = addr*3; dump_done on addr 31.
  - A dbg_req_valid raised during the dump is not accepted until IDLE.
- **Simultaneous dump_start and dbg_req_valid in IDLE:** dump starts, ready = 0, and the request is accepted after dump_done.
- **rst asserted in DBG_WR and at dump beat 10:** all outputs 0 next cycle, no dbg_rsp_valid, no dump_done, rf_we from the core only.

Source files
------------

// File: rtl/rf_arb_pkg.sv
// rf_arb_pkg: shared types and constants for the register-file access arbiter.
package rf_arb_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DBG_WR = 2'd1,
    ST_DBG_RD = 2'd2,
    ST_DUMP   = 2'd3
  } rf_arb_state_e;

  // Width of the debug-write starvation counter (STARVE_LIMIT fits in 1..15).
  localparam int STARVE_CNT_W = 4;

endpackage : rf_arb_pkg

// File: rtl/rf_dump_seq.sv
// rf_dump_seq: register-dump address counter and registered dump beat outputs.
// The counter restarts on start_i, advances while active_i and parks on the last
// register. Each active cycle produces one registered beat; done marks the last beat.
module rf_dump_seq
  import rf_arb_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              active_i,
  input  logic [DATA_W-1:0] sample_data_i,
  output logic [ADDR_W-1:0] cnt_o,
  output logic              last_o,
  output logic              dump_valid_o,
  output logic [ADDR_W-1:0] dump_addr_o,
  output logic [DATA_W-1:0] dump_data_o,
  output logic              dump_done_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              done_q, done_d;

  assign cnt_o        = cnt_q;
  assign last_o       = (cnt_q == LAST_ADDR);
  assign dump_valid_o = valid_q;
  assign dump_addr_o  = addr_q;
  assign dump_data_o  = data_q;
  assign dump_done_o  = done_q;

  // Next counter value and next beat: count up without wrapping, emit one beat per active cycle.
  always_comb begin
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    addr_d  = '0;
    data_d  = '0;
    done_d  = 1'b0;
    if (start_i) begin
      cnt_d = '0;
    end else if (active_i && !last_o) begin
      cnt_d = cnt_q + ADDR_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
    if (active_i) begin
      valid_d = 1'b1;
      addr_d  = cnt_q;
      data_d  = sample_data_i;
      done_d  = last_o;
    end else begin
      valid_d = 1'b0;
    end
  end

  // Counter and beat registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

endmodule : rf_dump_seq

// File: rtl/rf_access_arbiter.sv
// rf_access_arbiter: shares the register-file write port and an auxiliary read
// port between core writeback and a debug host, with an optional register dump.
// Optional feature macro: RF_ARB_DUMP_EN (compiles in the DUMP state and rf_dump_seq).
module rf_access_arbiter
  import rf_arb_pkg::*;
#(
  parameter int NUM_REGS     = 32,
  parameter int ADDR_W       = 5,
  parameter int DATA_W       = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              core_stall,
  input  logic              dbg_req_valid,
  input  logic              dbg_req_write,
  input  logic [ADDR_W-1:0] dbg_req_addr,
  input  logic [DATA_W-1:0] dbg_req_wdata,
  output logic              dbg_req_ready,
  output logic              dbg_rsp_valid,
  output logic [DATA_W-1:0] dbg_rsp_rdata,
  input  logic              dump_start,
  output logic              dump_valid,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_done,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [ADDR_W-1:0] rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata
);

  localparam logic [STARVE_CNT_W-1:0] STARVE_LIM = STARVE_CNT_W'(STARVE_LIMIT);

  rf_arb_state_e           state_q, state_d;
  logic [STARVE_CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [DATA_W-1:0]       wdata_q, wdata_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]       rsp_rdata_q, rsp_rdata_d;

  logic                    core_wins_s;
  logic                    dbg_grant_s;
  logic                    req_accept_s;
  logic [ADDR_W-1:0]       sample_addr_s;
  logic [DATA_W-1:0]       fwd_data_s;
  logic [ADDR_W-1:0]       dump_cnt_s;
  logic                    dump_last_s;

  assign dbg_rsp_valid = rsp_valid_q;
  assign dbg_rsp_rdata = rsp_rdata_q;

`ifdef RF_ARB_DUMP_EN
  logic dump_go_s;

  // dump_start only matters in IDLE, where it also beats a simultaneous debug request.
  assign dump_go_s     = (state_q == ST_IDLE) && dump_start && !rst;
  assign dbg_req_ready = (state_q == ST_IDLE) && !dump_start && !rst;

  rf_dump_seq #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W)
  ) u_dump_seq (
    .clk           (clk),
    .rst           (rst),
    .start_i       (dump_go_s),
    .active_i      (state_q == ST_DUMP),
    .sample_data_i (fwd_data_s),
    .cnt_o         (dump_cnt_s),
    .last_o        (dump_last_s),
    .dump_valid_o  (dump_valid),
    .dump_addr_o   (dump_addr),
    .dump_data_o   (dump_data),
    .dump_done_o   (dump_done)
  );
`else
  logic dump_start_unused_s;

  assign dump_start_unused_s = dump_start;
  assign dbg_req_ready       = (state_q == ST_IDLE) && !rst;
  assign dump_cnt_s          = '0;
  assign dump_last_s         = 1'b1;
  assign dump_valid          = 1'b0;
  assign dump_addr           = '0;
  assign dump_data           = '0;
  assign dump_done           = 1'b0;
`endif

  assign req_accept_s = dbg_req_valid && dbg_req_ready;

  // Write-port arbitration, stall, and aux read address with same-cycle writeback forwarding.
  always_comb begin
    core_wins_s = wb_en && (starve_cnt_q < STARVE_LIM);
    dbg_grant_s = (state_q == ST_DBG_WR) && !core_wins_s && !rst;
    core_stall  = (state_q == ST_DBG_WR) && wb_en && (starve_cnt_q == STARVE_LIM) && !rst;
    if (dbg_grant_s) begin
      rf_we    = 1'b1;
      rf_waddr = addr_q;
      rf_wdata = wdata_q;
    end else begin
      rf_we    = wb_en;
      rf_waddr = wb_addr;
      rf_wdata = wb_data;
    end
    if (state_q == ST_DUMP) begin
      sample_addr_s = dump_cnt_s;
    end else begin
      sample_addr_s = addr_q;
    end
    rf_raddr = sample_addr_s;
    if (wb_en && (wb_addr == sample_addr_s)) begin
      fwd_data_s = wb_data;
    end else begin
      fwd_data_s = rf_rdata;
    end
  end

  // FSM next state, request latching, starvation counting and response generation.
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rsp_valid_d  = 1'b0;
    rsp_rdata_d  = '0;
    case (state_q)
      ST_IDLE: begin
        if (req_accept_s) begin
          addr_d       = dbg_req_addr;
          wdata_d      = dbg_req_write ? dbg_req_wdata : '0;
          starve_cnt_d = '0;
          state_d      = dbg_req_write ? ST_DBG_WR : ST_DBG_RD;
        end
`ifdef RF_ARB_DUMP_EN
        else if (dump_go_s) begin
          state_d = ST_DUMP;
        end
`endif
        else begin
          state_d = ST_IDLE;
        end
      end
      ST_DBG_WR: begin
        if (core_wins_s) begin
          starve_cnt_d = starve_cnt_q + STARVE_CNT_W'(1);
          state_d      = ST_DBG_WR;
        end else begin
          starve_cnt_d = '0;
          rsp_valid_d  = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      ST_DBG_RD: begin
        rsp_valid_d = 1'b1;
        rsp_rdata_d = fwd_data_s;
        state_d     = ST_IDLE;
      end
      ST_DUMP: begin
        if (dump_last_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DUMP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and response registers; reset drops any pending request silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      starve_cnt_q <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
    end
  end

endmodule : rf_access_arbiter
